// File: rtl/uart_tx_cfg_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_pkg
// Shared definitions for the configurable UART transmitter:
//   - parity mode encodings as they appear on the parity_mode input
//   - transmit FSM state enumeration
//   - helpers that decide whether a parity bit is sent and what its value is
// ---------------------------------------------------------------------------
package uart_tx_cfg_pkg;

    // parity_mode encodings; code 3 is reserved and behaves like "none"
    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    // Largest payload the transmitter supports; parity helpers take words
    // zero-extended to this width so one function serves every build.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // A parity bit is only framed for the two defined parity modes.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

    // Even parity makes the total count of ones even (bit = XOR of data);
    // odd parity is its complement. Zero-extension does not change the XOR.
    function automatic logic parity_bit(input logic [1:0]               mode,
                                        input logic [MAX_DATA_BITS-1:0] word);
        return (mode == PARITY_ODD) ? ~(^word) : (^word);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_if
// Valid/ready write port of the UART transmitter.
//   tx_data  : word to transmit (DATA_BITS wide)
//   tx_valid : producer has a word on tx_data
//   tx_ready : transmitter FIFO can take a word this cycle
// A word transfers on any clock edge where tx_valid and tx_ready are both 1.
// Modports: master = producer, slave = transmitter.
// ---------------------------------------------------------------------------
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_sync_fifo
// Single-clock first-word-fall-through FIFO used as the transmit buffer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/level)
//   push/wdata : write request and data; ignored while full
//   pop        : consume the head word; ignored while empty
//   rdata      : head word, valid whenever empty is 0 (fall-through)
//   full/empty : occupancy flags
//   level      : number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module uart_tx_cfg_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;

    logic do_push;
    logic do_pop;

    // Guards live here too, so a misbehaving caller cannot overwrite a full
    // buffer or underflow an empty one.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Fall-through read: the head word is presented combinationally so the
    // consumer can latch it on the same edge it pops.
    assign rdata = mem[rd_ptr_reg];
    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Buffered UART transmitter with runtime baud divisor, parity and stop-bit
// selection. Words arrive on a valid/ready port into a FWFT FIFO and are
// framed onto TXD as: start(0), DATA_BITS data LSB first, optional parity,
// one or two stop(1) bits. Every bit lasts baud_div clocks (minimum 2).
// Ports:
//   clk          : system clock
//   RSTn         : asynchronous active-low reset; aborts any frame in flight
//   baud_div     : clocks per bit, values below 2 act as 2
//   parity_mode  : 0 none, 1 even, 2 odd, 3 none
//   stop2        : 1 selects two stop bits
//   bus          : write port (tx_data / tx_valid / tx_ready)
//   TXD          : serial output, idle high
//   busy         : a frame is on the line or words are waiting
//   fifo_level   : current FIFO occupancy
// Configuration is sampled only when a word is popped, so changes made while
// a frame is on the line apply from the next frame onwards.
// ---------------------------------------------------------------------------
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                         clk,
    input  logic                         RSTn,
    input  logic [DIV_W-1:0]             baud_div,
    input  logic [1:0]                   parity_mode,
    input  logic                         stop2,
    uart_tx_cfg_if.slave                 bus,
    output logic                         TXD,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // ------------------------------------------------------------------
    // Transmit buffer
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LW-1:0]        fifo_level_w;
    logic                 fifo_pop;

    uart_tx_cfg_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (RSTn),
        .push  (bus.tx_valid && !fifo_full),
        .wdata (bus.tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_w)
    );

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    tx_state_t             state_reg;
    logic [DIV_W-1:0]      baud_cnt_reg;   // counts div-1 .. 0 within a bit
    logic [DIV_W-1:0]      div_reg;        // divisor latched for this frame
    logic [BW-1:0]         bit_idx_reg;    // data bit currently on the line
    logic                  stop_cnt_reg;   // an extra stop bit is still owed
    logic [DATA_BITS-1:0]  shift_reg;      // remaining data bits, LSB next
    logic                  par_en_reg;
    logic                  par_bit_reg;
    logic                  txd_reg;

    logic [DIV_W-1:0]         div_eff;
    logic [MAX_DATA_BITS-1:0] word_ext;
    logic                     bit_end;
    logic                     frame_end;

    // Divisors 0 and 1 cannot produce a meaningful bit time; clamp to 2.
    assign div_eff  = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign word_ext = MAX_DATA_BITS'(fifo_rdata);

    // The last cycle of every bit time is the one where the counter is zero.
    assign bit_end   = (baud_cnt_reg == '0);
    assign frame_end = (state_reg == ST_STOP) && bit_end && !stop_cnt_reg;

    // A word is taken either from idle or exactly at the end of the final
    // stop bit; the latter chains frames with no idle gap on the line.
    assign fifo_pop = !fifo_empty && ((state_reg == ST_IDLE) || frame_end);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            div_reg      <= DIV_W'(2);
            bit_idx_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            txd_reg      <= 1'b1;
        end else if (fifo_pop) begin
            // Load a new frame: latch word and configuration, drive start.
            state_reg    <= ST_START;
            baud_cnt_reg <= div_eff - DIV_W'(1);
            div_reg      <= div_eff;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= stop2;
            shift_reg    <= fifo_rdata;
            par_en_reg   <= parity_enabled(parity_mode);
            par_bit_reg  <= parity_bit(parity_mode, word_ext);
            txd_reg      <= 1'b0;
        end else begin
            // Bit timer runs in every active state and reloads at bit end.
            if (state_reg != ST_IDLE) begin
                baud_cnt_reg <= bit_end ? (div_reg - DIV_W'(1))
                                        : (baud_cnt_reg - DIV_W'(1));
            end

            case (state_reg)
                ST_IDLE: begin
                    txd_reg <= 1'b1;
                end

                ST_START: begin
                    if (bit_end) begin
                        state_reg   <= ST_DATA;
                        bit_idx_reg <= '0;
                        txd_reg     <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == BW'(DATA_BITS - 1)) begin
                            if (par_en_reg) begin
                                state_reg <= ST_PARITY;
                                txd_reg   <= par_bit_reg;
                            end else begin
                                state_reg <= ST_STOP;
                                txd_reg   <= 1'b1;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BW'(1);
                            txd_reg     <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        state_reg <= ST_STOP;
                        txd_reg   <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        txd_reg <= 1'b1;
                        if (stop_cnt_reg) begin
                            stop_cnt_reg <= 1'b0;
                        end else begin
                            // Nothing queued (a queued word is handled by
                            // the pop branch above), so go quiet.
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    txd_reg   <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign TXD          = txd_reg;
    assign busy         = (state_reg != ST_IDLE) || (fifo_level_w != '0);
    assign fifo_level   = fifo_level_w;
    assign bus.tx_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
// Self-checking bench for uart_tx_cfg. The line is sampled every cycle and
// compared, frame by frame, with waveforms built from the framing rules
// (start, data LSB first, parity, stop bits, each repeated for a bit time).
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;
    localparam int DB = 8;
    localparam int FD = 16;
    localparam int DW = 16;
    localparam int LW = $clog2(FD) + 1;

    typedef struct {
        logic [8:0] word;
        int         div;
        logic [1:0] mode;
        bit         s2;
    } frame_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] baud_div;
    logic [1:0]    parity_mode;
    logic          stop2;
    logic          txd;
    logic          busy;
    logic [LW-1:0] fifo_level;

    uart_tx_cfg_if #(.DATA_BITS(DB)) bus ();

    uart_tx_cfg #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (FD),
        .DIV_W      (DW)
    ) dut (
        .clk         (clk),
        .RSTn        (rst_n),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .bus         (bus.slave),
        .TXD         (txd),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    logic   cap_q[$];
    bit     cap_go;
    bit     drv_done;
    frame_t frames[$];

    // ---------------- reference model ----------------
    function automatic int frame_len(input frame_t f);
        int d;
        int nbits;
        d = (f.div < 2) ? 2 : f.div;
        nbits = 1 + DB + ((f.mode == 2'd1 || f.mode == 2'd2) ? 1 : 0) + (f.s2 ? 2 : 1);
        return nbits * d;
    endfunction

    function automatic logic [255:0] frame_bits(input frame_t f);
        logic [255:0] v;
        logic         bits[$];
        logic         p;
        int           d;
        int           idx;
        v = '0;
        p = 1'b0;
        d = (f.div < 2) ? 2 : f.div;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) begin
            bits.push_back(f.word[i]);
            p = p ^ f.word[i];
        end
        if (f.mode == 2'd1) bits.push_back(p);
        else if (f.mode == 2'd2) bits.push_back(~p);
        bits.push_back(1'b1);
        if (f.s2) bits.push_back(1'b1);
        idx = 0;
        foreach (bits[b]) begin
            for (int r = 0; r < d; r++) begin
                v[idx] = bits[b];
                idx++;
            end
        end
        return v;
    endfunction

    function automatic logic [255:0] grab(input int start, input int len);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < len; i++)
            v[i] = (start + i < cap_q.size()) ? cap_q[start + i] : 1'bx;
        return v;
    endfunction

    // ---------------- stimulus / capture ----------------
    task automatic push_word(input logic [8:0] w);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.tx_data  = w[DB-1:0];
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        cap_go = 1'b1;
        #1 bus.tx_valid = 1'b0;
    endtask

    // Records TXD once per cycle from the first accepted push until the
    // transmitter is idle with the driver finished.
    task automatic capture(input int budget);
        int cyc;
        cyc = 0;
        cap_q.delete();
        forever begin
            @(negedge clk);
            if (cap_go) begin
                cap_q.push_back(txd);
                if (busy === 1'b0 && drv_done) break;
            end
            cyc++;
            if (cyc > budget) begin
                total++;
                bad++;
                $display("FAIL capture_timeout got=%0d cycles want<=%0d", cyc, budget);
                break;
            end
        end
    endtask

    function automatic int budget_for_frames();
        int b;
        b = 100;
        foreach (frames[i]) b += frame_len(frames[i]);
        return b;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", txd); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (fifo_level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        total++;
        if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.tx_ready); end
        $display("reset: txd=%b busy=%b level=%0d ready=%b", txd, busy, fifo_level, bus.tx_ready);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Single frames: reference pattern, parity variants, two stop bits,
    // and the clamped divisors 0 and 1.
    task automatic test_frame_formats;
        logic [8:0] t_word [6] = '{9'h0A5, 9'h007, 9'h007, 9'h007, 9'h05A, 9'h03C};
        int         t_div  [6] = '{4, 4, 4, 4, 0, 1};
        logic [1:0] t_mode [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2};
        bit         t_s2   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int pos;
        int len;
        logic [255:0] exp_v;
        logic [255:0] act_v;
        foreach (t_word[t]) begin
            baud_div    = DW'(t_div[t]);
            parity_mode = t_mode[t];
            stop2       = t_s2[t];
            frames.delete();
            frames.push_back('{t_word[t], t_div[t], t_mode[t], t_s2[t]});
            cap_go = 1'b0;
            drv_done = 1'b0;
            fork
                begin push_word(t_word[t]); drv_done = 1'b1; end
                capture(budget_for_frames());
            join
            pos = 1;
            total++;
            if (grab(0, 1) !== 256'd1) begin bad++; $display("FAIL fmt%0d lead_idle got=%b want=1", t, cap_q[0]); end
            foreach (frames[i]) begin
                len = frame_len(frames[i]);
                exp_v = frame_bits(frames[i]);
                act_v = grab(pos, len);
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL fmt%0d frame word=%h got=%h want=%h", t, frames[i].word, act_v, exp_v);
                end else
                    $display("fmt%0d frame word=%h div=%0d mode=%0d stop2=%0d len=%0d ok", t,
                             frames[i].word, frames[i].div, frames[i].mode, frames[i].s2, len);
                pos += len;
            end
            total++;
            if (cap_q.size() != pos + 1) begin bad++; $display("FAIL fmt%0d length got=%0d want=%0d", t, cap_q.size(), pos + 1); end
        end
    endtask

    // Fill the FIFO while the first frame is on the line, check the full
    // boundary, hold an extra word that must be refused, then check that
    // every accepted word goes out with no gap.
    task automatic test_back_to_back;
        int pos;
        int len;
        logic [8:0] w;
        logic [255:0] exp_v;
        logic [255:0] act_v;
        baud_div = DW'(2);
        parity_mode = 2'd0;
        stop2 = 1'b0;
        frames.delete();
        for (int i = 0; i < FD + 1; i++) begin
            w = 9'($urandom_range(0, (1 << DB) - 1));
            frames.push_back('{w, 2, 2'd0, 1'b0});
        end
        cap_go = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                foreach (frames[i]) push_word(frames[i].word);
                @(negedge clk);
                total++;
                if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b want=0", bus.tx_ready); end
                total++;
                if (fifo_level !== LW'(FD)) begin bad++; $display("FAIL b2b_full_level got=%0d want=%0d", fifo_level, FD); end
                bus.tx_data  = '1;
                bus.tx_valid = 1'b1;
                repeat (3) @(negedge clk);
                total++;
                if (fifo_level !== LW'(FD) || bus.tx_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_held got level=%0d ready=%b want level=%0d ready=0", fifo_level, bus.tx_ready, FD);
                end
                bus.tx_valid = 1'b0;
                drv_done = 1'b1;
            end
            capture(budget_for_frames());
        join
        pos = 1;
        total++;
        if (grab(0, 1) !== 256'd1) begin bad++; $display("FAIL b2b lead_idle got=%b want=1", cap_q[0]); end
        foreach (frames[i]) begin
            len = frame_len(frames[i]);
            exp_v = frame_bits(frames[i]);
            act_v = grab(pos, len);
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL b2b frame%0d word=%h got=%h want=%h", i, frames[i].word, act_v, exp_v);
            end else
                $display("b2b frame%0d word=%h len=%0d ok", i, frames[i].word, len);
            pos += len;
        end
        total++;
        if (cap_q.size() != pos + 1) begin bad++; $display("FAIL b2b length got=%0d want=%0d", cap_q.size(), pos + 1); end
    endtask

    // Divisor changed while frame 1 is on the line: frame 1 keeps 4 clocks
    // per bit, the queued frame 2 uses 8.
    task automatic test_config_change;
        int pos;
        int len;
        logic [255:0] exp_v;
        logic [255:0] act_v;
        baud_div = DW'(4);
        parity_mode = 2'd0;
        stop2 = 1'b0;
        frames.delete();
        frames.push_back('{9'h0C3, 4, 2'd0, 1'b0});
        frames.push_back('{9'h01E, 8, 2'd0, 1'b0});
        cap_go = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                push_word(frames[0].word);
                push_word(frames[1].word);
                repeat (10) @(negedge clk);
                baud_div = DW'(8);
                drv_done = 1'b1;
            end
            capture(budget_for_frames());
        join
        pos = 1;
        total++;
        if (grab(0, 1) !== 256'd1) begin bad++; $display("FAIL cfg lead_idle got=%b want=1", cap_q[0]); end
        foreach (frames[i]) begin
            len = frame_len(frames[i]);
            exp_v = frame_bits(frames[i]);
            act_v = grab(pos, len);
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cfg frame%0d word=%h got=%h want=%h", i, frames[i].word, act_v, exp_v);
            end else
                $display("cfg frame%0d word=%h div=%0d ok", i, frames[i].word, frames[i].div);
            pos += len;
        end
        total++;
        if (cap_q.size() != pos + 1) begin bad++; $display("FAIL cfg length got=%0d want=%0d", cap_q.size(), pos + 1); end
    endtask

    // Random bursts with random configuration, held constant per burst.
    task automatic test_random;
        int pos;
        int len;
        int n;
        int d;
        logic [1:0] m;
        bit s;
        logic [8:0] w;
        logic [255:0] exp_v;
        logic [255:0] act_v;
        for (int run = 0; run < 6; run++) begin
            d = $urandom_range(0, 6);
            m = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 5);
            baud_div = DW'(d);
            parity_mode = m;
            stop2 = s;
            frames.delete();
            for (int i = 0; i < n; i++) begin
                w = 9'($urandom_range(0, (1 << DB) - 1));
                frames.push_back('{w, d, m, s});
            end
            cap_go = 1'b0;
            drv_done = 1'b0;
            fork
                begin
                    foreach (frames[i]) push_word(frames[i].word);
                    drv_done = 1'b1;
                end
                capture(budget_for_frames());
            join
            pos = 1;
            total++;
            if (grab(0, 1) !== 256'd1) begin bad++; $display("FAIL rnd%0d lead_idle got=%b want=1", run, cap_q[0]); end
            foreach (frames[i]) begin
                len = frame_len(frames[i]);
                exp_v = frame_bits(frames[i]);
                act_v = grab(pos, len);
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL rnd%0d frame%0d word=%h got=%h want=%h", run, i, frames[i].word, act_v, exp_v);
                end else
                    $display("rnd%0d frame%0d word=%h div=%0d mode=%0d stop2=%0d ok", run, i,
                             frames[i].word, d, m, s);
                pos += len;
            end
            total++;
            if (cap_q.size() != pos + 1) begin bad++; $display("FAIL rnd%0d length got=%0d want=%0d", run, cap_q.size(), pos + 1); end
        end
    endtask

    // Reset during a data bit with three words queued.
    task automatic test_reset_midframe;
        bit stay_ok;
        baud_div = DW'(4);
        parity_mode = 2'd0;
        stop2 = 1'b0;
        push_word(9'h000);
        push_word(9'h0FF);
        push_word(9'h055);
        push_word(9'h0AA);
        // first pop one edge after the first push; start bit spans 4 clocks,
        // so six more edges lands inside the second data bit of 0x00
        repeat (6) @(posedge clk);
        #2;
        total++;
        if (txd !== 1'b0 || fifo_level !== LW'(3) || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got txd=%b level=%0d busy=%b want txd=0 level=3 busy=1", txd, fifo_level, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (txd !== 1'b1) begin bad++; $display("FAIL midrst_txd got=%b want=1", txd); end
        total++;
        if (fifo_level !== '0 || busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state got level=%0d busy=%b ready=%b want level=0 busy=0 ready=1", fifo_level, busy, bus.tx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stay_ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_level !== '0) stay_ok = 1'b0;
        end
        total++;
        if (!stay_ok) begin bad++; $display("FAIL midrst_no_resume got activity after reset want idle line"); end
        $display("midrst: txd=%b busy=%b level=%0d after reset", txd, busy, fifo_level);
    endtask

    initial begin
        rst_n        = 1'b0;
        baud_div     = DW'(4);
        parity_mode  = 2'd0;
        stop2        = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        cap_go       = 1'b0;
        drv_done     = 1'b0;
        test_reset();
        test_frame_formats();
        test_back_to_back();
        test_config_change();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog got=timeout want=completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
